// File: rtl/axis_tpg_pkg.sv
// Shared definitions for the multi-pixel test pattern generator:
// pattern codes, FSM states and the colour-bar lookup.
package axis_tpg_pkg;

    localparam logic [2:0] PAT_SOLID   = 3'd0;
    localparam logic [2:0] PAT_BARS    = 3'd1;
    localparam logic [2:0] PAT_HGRAD   = 3'd2;
    localparam logic [2:0] PAT_VGRAD   = 3'd3;
    localparam logic [2:0] PAT_CHECKER = 3'd4;
    localparam logic [2:0] PAT_RAMP    = 3'd5;
    localparam logic [2:0] PAT_SCROLL  = 3'd6;
    localparam logic [2:0] PAT_ZERO    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    // Bit k set means channel k (mod 3) is full: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [2:0] BAR_LUT [8] = '{3'd7, 3'd6, 3'd3, 3'd2, 3'd5, 3'd4, 3'd1, 3'd0};

    function automatic int min_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tpg_pixel_gen.sv
// Combinational pixel generator: one pixel of NUM_CH channels from its
// coordinates, the frame's pattern configuration and the frame count.
module tpg_pixel_gen
    import axis_tpg_pkg::*;
#(
    parameter int WIDTH      = 1920,
    parameter int HEIGHT     = 1080,
    parameter int PPC        = 2,
    parameter int NUM_CH     = 3,
    parameter int CH_WIDTH   = 8,
    parameter int CHECK_LOG2 = 5,
    parameter int FCNT_WIDTH = 16,
    parameter int XW         = min_bits(WIDTH),
    parameter int YW         = min_bits(HEIGHT)
) (
    input  logic [XW-1:0]              x,
    input  logic [YW-1:0]              y,
    input  logic [2:0]                 sel,
    input  logic [NUM_CH*CH_WIDTH-1:0] solid,
    input  logic [FCNT_WIDTH-1:0]      frame_cnt,
    output logic [NUM_CH*CH_WIDTH-1:0] pixel
);

    localparam int HW = XW + CH_WIDTH;
    localparam int VW = YW + CH_WIDTH;
    localparam int BW = XW + 3;
    localparam int SW = XW + FCNT_WIDTH + 3;
    localparam logic [HW-1:0] W_H = HW'(WIDTH);
    localparam logic [VW-1:0] H_V = VW'(HEIGHT);
    localparam logic [BW-1:0] W_B = BW'(WIDTH);
    localparam logic [SW-1:0] W_S = SW'(WIDTH);

    logic [CH_WIDTH-1:0] hval, vval, sval, rval;
    logic [CH_WIDTH:0]   rsum;
    logic [XW-1:0]       xs;
    logic [2:0]          bar;
    logic                chk;

    always_comb begin
        hval  = CH_WIDTH'((HW'(x) << CH_WIDTH) / W_H);
        vval  = CH_WIDTH'((VW'(y) << CH_WIDTH) / H_V);
        bar   = 3'((BW'(x) << 3) / W_B);
        // Scroll offsets x by PPC pixels per completed frame, wrapping within the line.
        xs    = XW'((SW'(x) + SW'(frame_cnt) * SW'(PPC)) % W_S);
        sval  = CH_WIDTH'((HW'(xs) << CH_WIDTH) / W_H);
        rsum  = {1'b0, hval} + {1'b0, vval};
        rval  = CH_WIDTH'(rsum >> 1);
        chk   = ((((32'(x) ^ 32'(y)) >> CHECK_LOG2) & 32'd1) != 32'd0);
        pixel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            case (sel)
                PAT_SOLID:   pixel[c*CH_WIDTH +: CH_WIDTH] = solid[c*CH_WIDTH +: CH_WIDTH];
                PAT_BARS:    pixel[c*CH_WIDTH +: CH_WIDTH] = BAR_LUT[bar][c%3] ? '1 : '0;
                PAT_HGRAD:   pixel[c*CH_WIDTH +: CH_WIDTH] = hval;
                PAT_VGRAD:   pixel[c*CH_WIDTH +: CH_WIDTH] = vval;
                PAT_CHECKER: pixel[c*CH_WIDTH +: CH_WIDTH] = chk ? '1 : '0;
                PAT_RAMP:    pixel[c*CH_WIDTH +: CH_WIDTH] = (c == 0) ? rval :
                                                             (c == 1) ? vval :
                                                             (c == 2) ? hval : '0;
                PAT_SCROLL:  pixel[c*CH_WIDTH +: CH_WIDTH] = sval;
                default:     pixel[c*CH_WIDTH +: CH_WIDTH] = '0;
            endcase
        end
    end

endmodule

// File: rtl/axis_tpg_mp.sv
// Multi-pixel AXI4-Stream test pattern generator: repeats frames while enabled,
// inserts an idle gap between frames and holds each beat until accepted.
//   state  | meaning
//   IDLE   | no output; waiting for en_i
//   ACTIVE | streaming beats of the current frame
//   GAP    | FRAME_GAP idle cycles before the next frame
module axis_tpg_mp
    import axis_tpg_pkg::*;
#(
    parameter int WIDTH      = 1920,
    parameter int HEIGHT     = 1080,
    parameter int PPC        = 2,
    parameter int NUM_CH     = 3,
    parameter int CH_WIDTH   = 8,
    parameter int CHECK_LOG2 = 5,
    parameter int FRAME_GAP  = 16,
    parameter int FCNT_WIDTH = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           en_i,
    input  logic [2:0]                     sel_i,
    input  logic [NUM_CH*CH_WIDTH-1:0]     solid_color_i,
    output logic                           m_axis_tvalid_o,
    input  logic                           m_axis_tready_i,
    output logic [PPC*NUM_CH*CH_WIDTH-1:0] m_axis_tdata_o,
    output logic                           m_axis_tlast_o,
    output logic                           m_axis_tuser_o,
    output logic [FCNT_WIDTH-1:0]          frame_cnt_o
);

    localparam int PW    = NUM_CH * CH_WIDTH;
    localparam int BEATS = WIDTH / PPC;
    localparam int XBW   = min_bits(BEATS);
    localparam int XW    = min_bits(WIDTH);
    localparam int YW    = min_bits(HEIGHT);
    localparam int GW    = min_bits(FRAME_GAP);
    localparam logic [XBW-1:0] XB_MAX   = XBW'(BEATS - 1);
    localparam logic [YW-1:0]  Y_MAX    = YW'(HEIGHT - 1);
    localparam logic [GW-1:0]  GAP_LAST = GW'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

    state_t              state, state_nxt;
    logic [XBW-1:0]      xb, ld_xb;
    logic [YW-1:0]       y, ld_y;
    logic [GW-1:0]       gap_cnt;
    logic [2:0]          sel_q, ld_sel;
    logic [PW-1:0]       solid_q, ld_solid;
    logic [FCNT_WIDTH-1:0] ld_fc;
    logic [PPC*PW-1:0]   pix;
    logic hit, last_beat, gap_done;
    logic start_frame, advance, frame_done, load;

    assign hit       = m_axis_tvalid_o & m_axis_tready_i;
    assign last_beat = (xb == XB_MAX) && (y == Y_MAX);
    assign gap_done  = (gap_cnt == GAP_LAST);
    assign load      = start_frame | advance;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (en_i) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (hit && last_beat) begin
                           if (!en_i)               state_nxt = ST_IDLE;
                           else if (FRAME_GAP == 0) state_nxt = ST_ACTIVE;
                           else                     state_nxt = ST_GAP;
                       end
            ST_GAP:    if (gap_done) state_nxt = en_i ? ST_ACTIVE : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        start_frame = 1'b0;
        advance     = 1'b0;
        frame_done  = 1'b0;
        case (state)
            ST_IDLE:   start_frame = en_i;
            ST_ACTIVE: if (hit) begin
                           if (last_beat) begin
                               frame_done  = 1'b1;
                               start_frame = en_i && (FRAME_GAP == 0);
                           end else begin
                               advance = 1'b1;
                           end
                       end
            ST_GAP:    start_frame = gap_done && en_i;
            default:   ;
        endcase
    end

    // Coordinates and configuration of the beat about to be loaded.
    always_comb begin
        ld_sel   = sel_q;
        ld_solid = solid_q;
        ld_fc    = frame_cnt_o;
        ld_xb    = xb + 1'b1;
        ld_y     = y;
        if (start_frame) begin
            ld_xb    = '0;
            ld_y     = '0;
            ld_sel   = sel_i;
            ld_solid = solid_color_i;
            ld_fc    = frame_done ? frame_cnt_o + 1'b1 : frame_cnt_o;
        end else if (xb == XB_MAX) begin
            ld_xb = '0;
            ld_y  = y + 1'b1;
        end
    end

    for (genvar p = 0; p < PPC; p++) begin : g_pix
        logic [XW-1:0] px;
        assign px = XW'(ld_xb) * XW'(PPC) + XW'(p);
        tpg_pixel_gen #(
            .WIDTH(WIDTH), .HEIGHT(HEIGHT), .PPC(PPC), .NUM_CH(NUM_CH),
            .CH_WIDTH(CH_WIDTH), .CHECK_LOG2(CHECK_LOG2), .FCNT_WIDTH(FCNT_WIDTH)
        ) u_pix (
            .x(px), .y(ld_y), .sel(ld_sel), .solid(ld_solid),
            .frame_cnt(ld_fc), .pixel(pix[p*PW +: PW])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            xb              <= '0;
            y               <= '0;
            gap_cnt         <= '0;
            sel_q           <= '0;
            solid_q         <= '0;
            frame_cnt_o     <= '0;
            m_axis_tvalid_o <= 1'b0;
            m_axis_tdata_o  <= '0;
            m_axis_tlast_o  <= 1'b0;
            m_axis_tuser_o  <= 1'b0;
        end else begin
            if (load) begin
                xb              <= ld_xb;
                y               <= ld_y;
                sel_q           <= ld_sel;
                solid_q         <= ld_solid;
                m_axis_tvalid_o <= 1'b1;
                m_axis_tdata_o  <= pix;
                m_axis_tlast_o  <= (ld_xb == XB_MAX);
                m_axis_tuser_o  <= (ld_xb == '0) && (ld_y == '0);
            end else if (frame_done) begin
                m_axis_tvalid_o <= 1'b0;
            end
            if (frame_done) frame_cnt_o <= frame_cnt_o + 1'b1;
            if (state == ST_GAP) gap_cnt <= gap_cnt + 1'b1;
            else                 gap_cnt <= '0;
        end
    end

endmodule
